mesi_bus_controller: RTL

// - Snooping-bus sequencer upstream of both per-core L1 caches in the MultiCore model.
// - Accepts one memory access at a time from the trace front end and splits the address into tag/index/offset.
// - Snoops the non-requesting core first, then runs the lookup/update on the requesting core.
// - Drives find_start, bus_signals and other_copy to the L1 blocks; counts completed transactions.

---
 rtl/mesi_bus_controller.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mesi_bus_controller.sv
// Snooping-bus sequencer: snoop the other core, then run the requester's L1 lookup/update.
// Optional per-command and snoop-hit statistics are enabled with `define BUS_STATS_EN.
module mesi_bus_controller #(
  parameter int way             = 4,
  parameter int block_size_byte = 16,
  parameter int cache_size_byte = 32*1024,
  parameter int TIMEOUT_CYCLES  = 1023,
  localparam int OFF_W = $clog2(block_size_byte),
  localparam int IDX_W = $clog2(cache_size_byte/(block_size_byte*way)),
  localparam int TAG_W = 32-IDX_W-OFF_W
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_core,
  input  logic [31:0]      req_addr,
  input  logic             req_type,
  output logic [TAG_W-1:0] tag,
  output logic [IDX_W-1:0] index,
  output logic [OFF_W-1:0] block_offset,
  output logic             ins_type,
  output logic             find_start_core1,
  output logic             find_start_core2,
  output logic [4:0]       bus_signals_core1,
  output logic [4:0]       bus_signals_core2,
  output logic             other_copy,
  input  logic             copy_core1,
  input  logic             copy_core2,
  input  logic             updated_core1,
  input  logic             updated_core2,
  output logic             txn_done,
  output logic [19:0]      txn_count,
  output logic             timeout_err
`ifdef BUS_STATS_EN
  ,
  output logic [19:0]      busrd_count,
  output logic [19:0]      busrdx_count,
  output logic [19:0]      snoop_hit_count
`endif
);

  typedef enum logic [2:0] {
    IDLE, SNOOP_START, SNOOP_WAIT, GAP1, REQ_START, REQ_WAIT, GAP2
  } state_t;

  state_t     state, state_nxt;
  logic       core;      // 0 = core1 requests, 1 = core2 requests
  logic [9:0] wd_cnt;
  logic       accept, wd_hit;
  logic       snp_copy, snp_upd, req_upd;
  logic [4:0] snp_bus, req_bus;

  assign accept   = req_valid && req_ready;
  assign snp_copy = core ? copy_core1    : copy_core2;
  assign snp_upd  = core ? updated_core1 : updated_core2;
  assign req_upd  = core ? updated_core2 : updated_core1;
  assign wd_hit   = (wd_cnt == 10'(TIMEOUT_CYCLES-1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    req_ready        = 1'b0;
    find_start_core1 = 1'b0;
    find_start_core2 = 1'b0;
    snp_bus          = 5'b0;
    req_bus          = 5'b0;
    txn_done         = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = SNOOP_START;
      end
      SNOOP_START: begin
        snp_bus = {2'b01, ins_type ? 3'b010 : 3'b100};
        if (core) find_start_core1 = 1'b1;
        else      find_start_core2 = 1'b1;
        state_nxt = SNOOP_WAIT;
      end
      SNOOP_WAIT: begin
        snp_bus = {2'b01, ins_type ? 3'b010 : 3'b100};
        if (snp_upd)     state_nxt = GAP1;
        else if (wd_hit) state_nxt = IDLE;
      end
      GAP1: state_nxt = REQ_START;
      REQ_START: begin
        req_bus = 5'b10000;
        if (core) find_start_core2 = 1'b1;
        else      find_start_core1 = 1'b1;
        state_nxt = REQ_WAIT;
      end
      REQ_WAIT: begin
        req_bus = 5'b10000;
        if (req_upd)     state_nxt = GAP2;
        else if (wd_hit) state_nxt = IDLE;
      end
      GAP2: begin
        txn_done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Snoop and request phases never overlap, so each core port just muxes by role.
  assign bus_signals_core1 = core ? snp_bus : req_bus;
  assign bus_signals_core2 = core ? req_bus : snp_bus;

  always_ff @(posedge clk) begin
    if (reset) begin
      core         <= 1'b0;
      tag          <= '0;
      index        <= '0;
      block_offset <= '0;
      ins_type     <= 1'b0;
      other_copy   <= 1'b0;
      wd_cnt       <= '0;
      txn_count    <= '0;
      timeout_err  <= 1'b0;
    end else begin
      if (accept) begin
        core         <= req_core;
        tag          <= req_addr[31:IDX_W+OFF_W];
        index        <= req_addr[IDX_W+OFF_W-1:OFF_W];
        block_offset <= req_addr[OFF_W-1:0];
        ins_type     <= req_type;
        other_copy   <= 1'b0;
      end
      if (state == SNOOP_WAIT) other_copy <= other_copy | snp_copy;
      if (state == GAP2) begin
        other_copy <= 1'b0;
        if (txn_count != 20'hFFFFF) txn_count <= txn_count + 20'd1;
      end
      // Watchdog restarts at every phase entry since START/GAP states sit between waits.
      if (state == SNOOP_WAIT || state == REQ_WAIT) wd_cnt <= wd_cnt + 10'd1;
      else                                           wd_cnt <= '0;
      if ((state == SNOOP_WAIT && !snp_upd && wd_hit) ||
          (state == REQ_WAIT   && !req_upd && wd_hit)) begin
        timeout_err <= 1'b1;
        other_copy  <= 1'b0;
      end
    end
  end

`ifdef BUS_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      busrd_count     <= '0;
      busrdx_count    <= '0;
      snoop_hit_count <= '0;
    end else begin
      if (state == SNOOP_START) begin
        if (ins_type) begin
          if (busrdx_count != 20'hFFFFF) busrdx_count <= busrdx_count + 20'd1;
        end else begin
          if (busrd_count != 20'hFFFFF) busrd_count <= busrd_count + 20'd1;
        end
      end
      if (state == GAP1 && other_copy && snoop_hit_count != 20'hFFFFF)
        snoop_hit_count <= snoop_hit_count + 20'd1;
    end
  end
`endif

endmodule
